axi_rd_resp_gen: RTL and testbench

AXI_RD_RESP_GEN -- requirements
Module: axi_rd_resp_gen

---
 rtl/axi_rd_pkg.sv | 23 ++
 rtl/axi_sync_fifo.sv | 57 +++++
 rtl/axi_rd_resp_gen.sv | 172 +++++++++++++++++
 tb/tb_axi_rd_resp_gen.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-response generator.
package axi_rd_pkg;

   // Payload widths carried by the R-channel beat record
   localparam int unsigned R_ID_W   = 16;
   localparam int unsigned R_DATA_W = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rd_state_e;

   typedef struct packed {
      logic [R_ID_W-1:0]   id;
      logic [R_DATA_W-1:0] data;
      logic [1:0]          resp;
      logic                last;
   } r_beat_t;

endpackage

// File: rtl/axi_sync_fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module axi_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // Status flags, qualified handshakes and head-of-queue data
   always_comb begin
      full_o  = (count_q == (PW + 1)'(DEPTH));
      empty_o = (count_q == '0);
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      rdata_o = mem_q[rd_ptr_q];
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/axi_rd_resp_gen.sv
// AXI read-response generator: queues read commands, fetches INCR bursts
// from a 1-cycle-latency memory and returns them on the R channel in order.
module axi_rd_resp_gen
   import axi_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ID_MAX_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned MEM_AW       = 10,
   parameter int unsigned CMD_DEPTH    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ID_MAX_WIDTH-1:0] cmd_id,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [7:0]              cmd_len,
   output logic                    mem_rd_en,
   output logic [MEM_AW-1:0]       mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [ID_MAX_WIDTH-1:0] rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast
);

   localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int unsigned WAW        = ADDR_WIDTH - BYTE_SHIFT;
   localparam int unsigned CMD_W      = ID_MAX_WIDTH + ADDR_WIDTH + 8;

   // Command queue
   logic                    cmd_push;
   logic                    cmd_pop;
   logic                    cmd_full;
   logic                    cmd_empty;
   logic [CMD_W-1:0]        cmd_head;
   logic [ID_MAX_WIDTH-1:0] head_id;
   logic [ADDR_WIDTH-1:0]   head_addr;
   logic [7:0]              head_len;

   // Burst sequencer state
   rd_state_e               state_q;
   logic [ID_MAX_WIDTH-1:0] id_q;
   logic [WAW-1:0]          waddr_q;
   logic [8:0]              beats_q;
   logic                    issue;
   logic                    last_beat;
   logic                    beat_err;
   logic [1:0]              buf_occ;
   logic [1:0]              credit_used;

   // Beat returning from memory this cycle
   logic                    ret_valid_q;
   logic                    ret_err_q;
   logic                    ret_last_q;
   logic [ID_MAX_WIDTH-1:0] ret_id_q;

   // Output buffer
   r_beat_t                 ret_beat;
   r_beat_t                 buf_head;
   r_beat_t                 out_beat;
   logic                    buf_push;
   logic                    buf_pop;
   logic                    buf_full;
   logic                    buf_empty;

   // Command acceptance and head-of-queue field split
   always_comb begin
      cmd_ready = !cmd_full && !rst;
      cmd_push  = cmd_valid && cmd_ready;
      {head_id, head_addr, head_len} = cmd_head;
   end

   axi_sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cmd_push),
      .wdata_i ({cmd_id, cmd_addr, cmd_len}),
      .pop_i   (cmd_pop),
      .rdata_o (cmd_head),
      .full_o  (cmd_full),
      .empty_o (cmd_empty)
   );

   // Issue credit, out-of-range detection and command pop decision
   always_comb begin
      buf_occ     = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
      credit_used = buf_occ + {1'b0, ret_valid_q};
      issue       = (state_q == ST_BURST) && (credit_used < 2'd2);
      last_beat   = (beats_q == 9'd1);
      beat_err    = ((waddr_q >> MEM_AW) != '0);
      cmd_pop     = !cmd_empty && ((state_q == ST_IDLE) || (issue && last_beat));
      mem_rd_en   = issue && !beat_err;
      mem_rd_addr = waddr_q[MEM_AW-1:0];
   end

   // Burst FSM: loads commands, steps the word address, tracks the returning beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         id_q        <= '0;
         waddr_q     <= '0;
         beats_q     <= '0;
         ret_valid_q <= 1'b0;
         ret_err_q   <= 1'b0;
         ret_last_q  <= 1'b0;
         ret_id_q    <= '0;
      end else begin
         ret_valid_q <= issue;
         if (issue) begin
            ret_err_q  <= beat_err;
            ret_last_q <= last_beat;
            ret_id_q   <= id_q;
         end
         if (cmd_pop) begin
            state_q <= ST_BURST;
            id_q    <= head_id;
            waddr_q <= WAW'(head_addr >> BYTE_SHIFT);
            beats_q <= {1'b0, head_len} + 9'd1;
         end else if (issue) begin
            if (last_beat) begin
               state_q <= ST_IDLE;
            end else begin
               waddr_q <= waddr_q + 1'b1;
               beats_q <= beats_q - 9'd1;
            end
         end
      end
   end

   // A returning beat is presented directly when the buffer is empty and is
   // only written into the buffer if it is not taken that same cycle; this
   // keeps the first-beat latency at three cycles while payload stays stable.
   always_comb begin
      ret_beat = '0;
      if (ret_valid_q) begin
         ret_beat.id   = R_ID_W'(ret_id_q);
         ret_beat.data = ret_err_q ? '0 : R_DATA_W'(mem_rd_data);
         ret_beat.resp = ret_err_q ? RESP_SLVERR : RESP_OKAY;
         ret_beat.last = ret_last_q;
      end
      out_beat = buf_empty ? ret_beat : buf_head;
      rvalid   = !buf_empty || ret_valid_q;
      buf_push = ret_valid_q && !(buf_empty && rready);
      buf_pop  = !buf_empty && rready;
      rid      = ID_MAX_WIDTH'(out_beat.id);
      rdata    = DATA_WIDTH'(out_beat.data);
      rresp    = out_beat.resp;
      rlast    = out_beat.last;
   end

   axi_sync_fifo #(
      .WIDTH ($bits(r_beat_t)),
      .DEPTH (2)
   ) u_out_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (buf_push),
      .wdata_i (ret_beat),
      .pop_i   (buf_pop),
      .rdata_o (buf_head),
      .full_o  (buf_full),
      .empty_o (buf_empty)
   );

endmodule

// File: tb/tb_axi_rd_resp_gen.sv
// Scoreboard bench for axi_rd_resp_gen with a 1-cycle-latency memory model.
module tb_axi_rd_resp_gen;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_id;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        mem_rd_en;
   logic [9:0]  mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic        rvalid;
   logic        rready;
   logic [15:0] rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   typedef struct {
      logic [15:0] id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          rd_cnt  = 0;
   int          acc_cnt = 0;
   logic [31:0] mem [1024];

   bit          prev_stall = 0;
   logic [15:0] p_id;
   logic [31:0] p_data;
   logic [1:0]  p_resp;
   logic        p_last;

   axi_rd_resp_gen #(
      .DATA_WIDTH   (32),
      .ID_MAX_WIDTH (16),
      .ADDR_WIDTH   (32),
      .MEM_AW       (10),
      .CMD_DEPTH    (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_id      (cmd_id),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .rvalid      (rvalid),
      .rready      (rready),
      .rid         (rid),
      .rdata       (rdata),
      .rresp       (rresp),
      .rlast       (rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
   end

   // Memory model: data valid exactly one cycle after the read strobe
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 32'hDEAD_BEEF;
   end

   // Monitor: scoreboard compare, payload hold while stalled, read credit
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         rd_cnt     = 0;
         acc_cnt    = 0;
         prev_stall = 0;
      end else begin
         if (mem_rd_en === 1'b1) begin
            rd_cnt++;
            total++;
            if (rd_cnt - acc_cnt > 2) begin
               bad++;
               $display("FAIL credit: outstanding reads=%0d required<=2", rd_cnt - acc_cnt);
            end
         end
         if (prev_stall) begin
            total++;
            if (rvalid !== 1'b1 || rid !== p_id || rdata !== p_data || rresp !== p_resp || rlast !== p_last) begin
               bad++;
               $display("FAIL hold: got v=%0b id=%h d=%h r=%0d l=%0b required v=1 id=%h d=%h r=%0d l=%0b",
                        rvalid, rid, rdata, rresp, rlast, p_id, p_data, p_resp, p_last);
            end
         end
         if (rvalid === 1'b1 && rready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL beat_unexpected: got id=%h d=%h r=%0d l=%0b required no beat", rid, rdata, rresp, rlast);
            end else begin
               e = sb.pop_front();
               if (rid !== e.id || rdata !== e.data || rresp !== e.resp || rlast !== e.last) begin
                  bad++;
                  $display("FAIL beat: got id=%h d=%h r=%0d l=%0b required id=%h d=%h r=%0d l=%0b",
                           rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
               end
            end
            if (rresp === 2'b00) acc_cnt++;
         end
         prev_stall = (rvalid === 1'b1) && (rready !== 1'b1);
         p_id   = rid;
         p_data = rdata;
         p_resp = rresp;
         p_last = rlast;
      end
   end

   // Drives one command and records its expected beats when it is accepted
   task automatic send_cmd(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len);
      bit          ok;
      logic [29:0] w;
      exp_t        e;
      ok        = 0;
      cmd_valid = 1'b1;
      cmd_id    = id;
      cmd_addr  = addr;
      cmd_len   = len;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            @(posedge clk);
            ok = 1;
            for (int b = 0; b <= int'(len); b++) begin
               w      = addr[31:2] + 30'(b);
               e.id   = id;
               e.last = (b == int'(len));
               if (w < 30'd1024) begin
                  e.data = 32'(w);
                  e.resp = 2'b00;
               end else begin
                  e.data = '0;
                  e.resp = 2'b10;
               end
               sb.push_back(e);
            end
            #1;
         end
      end
      cmd_valid = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL cmd_accept: id=%h got not accepted required accepted within 60 cycles", id);
      end
   endtask

   // Waits for the scoreboard to empty, optionally toggling rready randomly
   task automatic wait_drain(input bit rnd, output bit timed_out);
      timed_out = 1;
      for (int i = 0; i < 400; i++) begin
         if (sb.size() == 0) begin
            timed_out = 0;
            break;
         end
         @(posedge clk);
         #1;
         if (rnd) rready = ($urandom_range(0, 2) == 0);
      end
      rready = 1'b1;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_id    = '0;
      cmd_addr  = '0;
      cmd_len   = '0;
      rready    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 || rid !== 16'h0 || rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_r: got v=%0b l=%0b r=%0d id=%h d=%h required all zero", rvalid, rlast, rresp, rid, rdata);
      end
      total++;
      if (mem_rd_en !== 1'b0 || mem_rd_addr !== 10'h0) begin
         bad++;
         $display("FAIL reset_mem: got en=%0b addr=%h required en=0 addr=0", mem_rd_en, mem_rd_addr);
      end
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: got %0b required 0", cmd_ready);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL release_ready: got %0b required 1", cmd_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_burst;
      bit to;
      rready = 1'b1;
      send_cmd(16'h0005, 32'h40, 8'd3);
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0) begin
         bad++;
         $display("FAIL lat_c1: got rvalid=%0b required 0", rvalid);
      end
      @(negedge clk);
      total++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 10'h010 || rvalid !== 1'b0) begin
         bad++;
         $display("FAIL lat_c2: got en=%0b addr=%h v=%0b required en=1 addr=010 v=0", mem_rd_en, mem_rd_addr, rvalid);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (rvalid !== 1'b1) begin
            bad++;
            $display("FAIL lat_beat%0d: got rvalid=%0b required 1", k, rvalid);
         end
      end
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0) begin
         bad++;
         $display("FAIL lat_tail: got rvalid=%0b required 0", rvalid);
      end
      @(posedge clk);
      #1;
      wait_drain(0, to);
      total++;
      if (to || sb.size() != 0) begin
         bad++;
         $display("FAIL single_drain: got %0d pending required 0", sb.size());
      end
   endtask

   task automatic test_back_to_back;
      int run;
      bit seen;
      run    = 0;
      seen   = 0;
      rready = 1'b1;
      send_cmd(16'h0001, 32'h80, 8'd1);
      send_cmd(16'h0002, 32'h100, 8'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rvalid === 1'b1) begin
            seen = 1;
            run++;
         end else if (seen) begin
            break;
         end
      end
      total++;
      if (run != 4) begin
         bad++;
         $display("FAIL b2b_run: got %0d consecutive beats required 4", run);
      end
      @(posedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain: got %0d pending required 0", sb.size());
      end
   endtask

   task automatic test_random_ready;
      bit to;
      rready = 1'b0;
      send_cmd(16'h0005, 32'h40, 8'd3);
      send_cmd(16'h000A, 32'h1000, 8'd5);
      wait_drain(1, to);
      total++;
      if (to || sb.size() != 0) begin
         bad++;
         $display("FAIL rand_drain: got %0d pending required 0", sb.size());
      end
   endtask

   task automatic test_slverr;
      bit to;
      int r0;
      rready = 1'b1;
      r0     = rd_cnt;
      send_cmd(16'h0033, 32'hFFC, 8'd1);
      wait_drain(0, to);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (to || sb.size() != 0) begin
         bad++;
         $display("FAIL slverr_drain: got %0d pending required 0", sb.size());
      end
      total++;
      if (rd_cnt - r0 != 1) begin
         bad++;
         $display("FAIL slverr_reads: got %0d mem reads required 1", rd_cnt - r0);
      end
   endtask

   task automatic test_fifo_full;
      bit to;
      int r0;
      rready = 1'b0;
      r0     = rd_cnt;
      for (int k = 0; k < 5; k++) begin
         send_cmd(16'(16'h0011 + k), 32'(32'h400 + 32'h40 * k), 8'd3);
      end
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ready: got %0b required 0", cmd_ready);
      end
      repeat (5) @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0 || rvalid !== 1'b1 || rd_cnt - r0 != 2) begin
         bad++;
         $display("FAIL full_stall: got ready=%0b v=%0b reads=%0d required ready=0 v=1 reads=2",
                  cmd_ready, rvalid, rd_cnt - r0);
      end
      @(posedge clk);
      #1 rready = 1'b1;
      wait_drain(0, to);
      total++;
      if (to || sb.size() != 0) begin
         bad++;
         $display("FAIL full_drain: got %0d pending required 0", sb.size());
      end
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL full_recover: got ready=%0b required 1", cmd_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      bit to;
      bit stale;
      rready = 1'b1;
      send_cmd(16'h0007, 32'h200, 8'd7);
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(negedge clk);
      total++;
      if (rvalid !== 1'b0 || mem_rd_en !== 1'b0 || cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got v=%0b en=%0b ready=%0b required 0 0 0", rvalid, mem_rd_en, cmd_ready);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      stale = 0;
      repeat (3) begin
         @(negedge clk);
         if (rvalid !== 1'b0 || mem_rd_en !== 1'b0) stale = 1;
      end
      total++;
      if (stale) begin
         bad++;
         $display("FAIL mid_stale: got activity after release required none");
      end
      @(posedge clk);
      #1;
      send_cmd(16'h0009, 32'h300, 8'd2);
      wait_drain(0, to);
      total++;
      if (to || sb.size() != 0) begin
         bad++;
         $display("FAIL mid_drain: got %0d pending required 0", sb.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_random_ready();
      test_slverr();
      test_fifo_full();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
